oram_byte_fetch: RTL and testbench
==================================

ORAM_BYTE_FETCH -- requirements
Module: oram_byte_fetch

Interface
REQ-001 SHALL provide parameter ADDR_W, default 11: CPU byte-address width.
REQ-002 SHALL provide parameter WORD_BYTES, default 4: bytes per RAM word, power of two, 2..8; WB = log2(WORD_BYTES).
REQ-003 SHALL provide parameter RAM_LATENCY, default 1: cycles from oram_csb low to oram_value valid, 1..4.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: wb_clk_i  in  1  clock (all state on rising edge); wb_rst_i  in  1  reset.
REQ-005 SHALL have: req_valid  in  1  CPU fetch request.
REQ-006 SHALL have: req_addr  in  ADDR_W  byte address of the request.
REQ-007 SHALL have: req_ready  out  1  request accepted when high with req_valid.
REQ-008 SHALL have: rsp_valid  out  1  one-cycle response strobe.
REQ-009 SHALL have: rsp_data  out  8  fetched byte.
REQ-010 SHALL have: flush  in  1  invalidate line buffer.
REQ-011 SHALL have: oram_csb  out  1  RAM read select, active low.
REQ-012 SHALL have: oram_addr  out  ADDR_W-WB  RAM word address.
REQ-013 SHALL have: oram_value  in  8*WORD_BYTES  RAM read data.
REQ-014 SHALL have: miss_count  out  16  saturating miss counter.

Function
REQ-015 SHALL hold a one-word line buffer: data, tag (ADDR_W-WB bits), valid bit.
REQ-016 Hit SHALL mean valid=1, tag==req_addr[ADDR_W-1:WB], flush=0 in the same cycle.
REQ-017 Byte select SHALL be little-endian byte-granular: byte k = word bits [8k+7:8k], k = addr[WB-1:0].
REQ-018 FSM states SHALL be IDLE, READ, WAIT, RESP; req_ready=1 only in IDLE.
REQ-019 IDLE + req_valid + hit: stay IDLE; rsp_valid=1 with selected buffered byte exactly 1 cycle after accept.
REQ-020 IDLE + req_valid + miss: latch address, go READ; miss_count +1, holds at 0xFFFF.
REQ-021 READ: oram_csb=0 for exactly one cycle, oram_addr=latched word address; go WAIT with counter=RAM_LATENCY.
REQ-022 WAIT: decrement each cycle; in cycle where counter reaches 1, capture oram_value into buffer, set tag, go RESP.
REQ-023 RESP: rsp_valid=1 for one cycle with selected byte of captured word; return IDLE; miss response arrives RAM_LATENCY+2 cycles after accept.
REQ-024 oram_csb SHALL be 1 in all states except READ; oram_addr holds last value otherwise.
REQ-025 flush SHALL clear valid next edge; flush with request in IDLE forces miss.
REQ-026 flush during READ/WAIT/RESP: fetch completes and responds normally, but valid stays 0 after fill.
REQ-027 rsp_data SHALL hold last value when rsp_valid=0; req_valid while req_ready=0 is ignored, not queued.
REQ-028 Back-to-back hits SHALL sustain one response per cycle.

Reset
REQ-029 wb_rst_i=1 SHALL immediately force: state IDLE, valid=0, tag=0, oram_csb=1, oram_addr=0, rsp_valid=0, rsp_data=0, miss_count=0, counter=0.
REQ-030 Reset mid-fetch SHALL abandon the fetch with no response; first request after release is a miss.

Verification
REQ-031 Defaults, RAM word 2 = 0x44332211; req addr 0x009 -> csb low 1 cycle with oram_addr=2, rsp_valid 3 cycles after accept, rsp_data=0x22, miss_count=1.
REQ-032 After REQ-031, reqs 0x008,0x00A,0x00B consecutive cycles -> three hits, rsp_data 0x11,0x33,0x44 on consecutive cycles, miss_count stays 1.
REQ-033 flush pulse then req 0x008 -> miss, csb low, rsp_data=0x11, miss_count=2.
REQ-034 flush asserted during WAIT of miss to 0x00C -> response delivered; following req 0x00C is a miss again.
REQ-035 wb_rst_i pulsed during WAIT -> no rsp_valid, csb=1, miss_count=0; next req misses.
REQ-036 WORD_BYTES=8, RAM_LATENCY=3, word 0 = 0x8877665544332211, req 0x005 -> rsp 5 cycles after accept, rsp_data=0x66.

Source files
------------

// File: rtl/oram_byte_fetch_if.sv
// CPU fetch / RAM read bundle for oram_byte_fetch: request/response handshake,
// flush, RAM port and miss statistics.
interface oram_byte_fetch_if #(
  parameter int ADDR_W     = 11,
  parameter int WORD_BYTES = 4
);
  localparam int WB = $clog2(WORD_BYTES);

  logic                    req_valid;
  logic [ADDR_W-1:0]       req_addr;
  logic                    req_ready;
  logic                    rsp_valid;
  logic [7:0]              rsp_data;
  logic                    flush;
  logic                    oram_csb;
  logic [ADDR_W-WB-1:0]    oram_addr;
  logic [8*WORD_BYTES-1:0] oram_value;
  logic [15:0]             miss_count;

  modport slave (
    input  req_valid, req_addr, flush, oram_value,
    output req_ready, rsp_valid, rsp_data, oram_csb, oram_addr, miss_count
  );

  modport master (
    output req_valid, req_addr, flush, oram_value,
    input  req_ready, rsp_valid, rsp_data, oram_csb, oram_addr, miss_count
  );
endinterface

// File: rtl/oram_byte_fetch.sv
// Byte fetch unit in front of a word-wide read-only RAM, with a one-word line
// buffer so that accesses to the same word are served without a RAM read.
module oram_byte_fetch #(
  parameter int ADDR_W      = 11,
  parameter int WORD_BYTES  = 4,
  parameter int RAM_LATENCY = 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  oram_byte_fetch_if.slave    bus
);
  localparam int WB    = $clog2(WORD_BYTES);
  localparam int TAG_W = ADDR_W - WB;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic                    valid_q, valid_d;
  logic [TAG_W-1:0]        tag_q, tag_d;
  logic [8*WORD_BYTES-1:0] word_q, word_d;
  logic [WB-1:0]           off_q, off_d;
  logic [TAG_W-1:0]        oram_addr_q, oram_addr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [15:0]             miss_q, miss_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [7:0]              rsp_data_q, rsp_data_d;
  logic                    flushed_q, flushed_d;

  logic [TAG_W-1:0] req_tag;
  logic [WB-1:0]    req_off;
  logic             hit;
  logic [7:0]       buf_bytes [WORD_BYTES];
  logic [7:0]       ram_bytes [WORD_BYTES];

  // Little-endian byte lanes of the buffered word and of the incoming RAM word.
  for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_bytes
    assign buf_bytes[gi] = word_q[8*gi +: 8];
    assign ram_bytes[gi] = bus.oram_value[8*gi +: 8];
  end

  assign req_tag = bus.req_addr[ADDR_W-1:WB];
  assign req_off = bus.req_addr[WB-1:0];
  assign hit     = valid_q && (tag_q == req_tag) && !bus.flush;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    word_d      = word_q;
    off_d       = off_q;
    oram_addr_d = oram_addr_q;
    cnt_d       = cnt_q;
    miss_d      = miss_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    flushed_d   = flushed_q;

    if (bus.flush) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (hit) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = buf_bytes[req_off];
          end else begin
            oram_addr_d = req_tag;
            off_d       = req_off;
            flushed_d   = 1'b0;
            miss_d      = (miss_q == 16'hFFFF) ? miss_q : miss_q + 16'd1;
            state_d     = S_READ;
          end
        end
      end
      S_READ: begin
        cnt_d   = CNT_W'(RAM_LATENCY);
        state_d = S_WAIT;
        if (bus.flush) flushed_d = 1'b1;
      end
      S_WAIT: begin
        if (bus.flush) flushed_d = 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          // A flush seen at any point of the fetch keeps the filled line invalid.
          word_d      = bus.oram_value;
          tag_d       = oram_addr_q;
          valid_d     = !(flushed_q || bus.flush);
          rsp_valid_d = 1'b1;
          rsp_data_d  = ram_bytes[off_q];
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      valid_q     <= 1'b0;
      tag_q       <= '0;
      word_q      <= '0;
      off_q       <= '0;
      oram_addr_q <= '0;
      cnt_q       <= '0;
      miss_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      flushed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      word_q      <= word_d;
      off_q       <= off_d;
      oram_addr_q <= oram_addr_d;
      cnt_q       <= cnt_d;
      miss_q      <= miss_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      flushed_q   <= flushed_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.oram_csb   = (state_q != S_READ);
  assign bus.oram_addr  = oram_addr_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.miss_count = miss_q;
endmodule

// File: tb/tb_oram_byte_fetch.sv
// Bench for oram_byte_fetch: directed scenarios plus random traffic against a
// line-buffer model, on a default instance and an 8-byte/latency-3 instance.
module tb_oram_byte_fetch;
  localparam int AW  = 11;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  oram_byte_fetch_if #(.ADDR_W(AW), .WORD_BYTES(4)) ifa ();
  oram_byte_fetch_if #(.ADDR_W(AW), .WORD_BYTES(8)) ifb ();

  oram_byte_fetch #(.ADDR_W(AW), .WORD_BYTES(4), .RAM_LATENCY(LAT)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(ifa.slave));
  oram_byte_fetch #(.ADDR_W(AW), .WORD_BYTES(8), .RAM_LATENCY(3)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(ifb.slave));

  // RAM models: data is only meaningful exactly LATENCY cycles after a select.
  logic [31:0] mem_a [512];
  logic [63:0] mem_b [256];
  logic        a_pv = 1'b0;
  logic [8:0]  a_pa = '0;
  logic [2:0]  b_pv = '0;
  logic [7:0]  b_pa [3];

  always @(posedge clk) begin
    a_pv    <= !ifa.oram_csb;
    a_pa    <= ifa.oram_addr;
    b_pv    <= {b_pv[1:0], !ifb.oram_csb};
    b_pa[0] <= ifb.oram_addr;
    b_pa[1] <= b_pa[0];
    b_pa[2] <= b_pa[1];
  end
  assign ifa.oram_value = a_pv    ? mem_a[a_pa]    : 32'hDEAD_BEEF;
  assign ifb.oram_value = b_pv[2] ? mem_b[b_pa[2]] : 64'hDEAD_BEEF_CAFE_F00D;

  int         csb_lows_a = 0;
  logic [8:0] csb_addr_a = '0;
  always @(negedge clk) begin
    if (!ifa.oram_csb) begin
      csb_lows_a <= csb_lows_a + 1;
      csb_addr_a <= ifa.oram_addr;
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference line buffer.
  logic        m_valid = 1'b0;
  logic [8:0]  m_tag   = '0;
  logic [31:0] m_word  = '0;
  int          m_miss  = 0;
  logic [7:0]  m_last  = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] off);
    return 8'(w >> (8 * int'(off)));
  endfunction

  task automatic flush_pulse();
    @(negedge clk);
    ifa.flush = 1'b1;
    @(negedge clk);
    ifa.flush = 1'b0;
    m_valid = 1'b0;
    $display("txn flush");
  endtask

  // One request; fk>0 pulses flush k cycles after accept (misses only),
  // junk keeps presenting requests while the unit is busy.
  task automatic issue(input logic [10:0] addr, input int fk, input bit junk);
    bit         hit;
    int         fke, exp_lat, lat, lows0;
    logic [7:0] exp_d, got;
    hit = m_valid && (m_tag == addr[10:2]);
    fke = hit ? 0 : fk;
    if (!hit) begin
      m_word  = mem_a[addr[10:2]];
      m_tag   = addr[10:2];
      m_valid = 1'b1;
      if (m_miss < 65535) m_miss++;
    end
    if (fke > 0) m_valid = 1'b0;
    exp_d   = pick(m_word, addr[1:0]);
    exp_lat = hit ? 1 : LAT + 2;

    @(negedge clk);
    check("rsp_valid_one_cycle", ifa.rsp_valid, 0);
    check("rsp_data_hold", ifa.rsp_data, m_last);
    check("req_ready_idle", ifa.req_ready, 1);
    lows0 = csb_lows_a;
    ifa.req_valid = 1'b1;
    ifa.req_addr  = addr;
    lat = 0;
    got = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) ifa.req_valid = 1'b0;
      if (ifa.rsp_valid) begin
        lat = k;
        got = ifa.rsp_data;
        break;
      end
      ifa.flush = (k == fke);
      if (junk && k >= 2) begin
        ifa.req_valid = 1'b1;
        ifa.req_addr  = 11'($urandom);
      end
    end
    ifa.flush     = 1'b0;
    ifa.req_valid = 1'b0;
    check("latency", lat, exp_lat);
    check("rsp_data", got, exp_d);
    check("miss_count", ifa.miss_count, 16'(m_miss));
    check("csb_pulses", csb_lows_a - lows0, hit ? 0 : 1);
    if (!hit) check("oram_addr", csb_addr_a, addr[10:2]);
    m_last = exp_d;
    $display("txn addr=%03h hit=%0d flush_at=%0d junk=%0d lat=%0d data=%02h miss_count=%0d",
             addr, hit, fke, junk, lat, got, ifa.miss_count);
  endtask

  // Three back-to-back requests into the currently buffered word.
  task automatic burst(input logic [8:0] w, input logic [1:0] o0, input logic [1:0] o1,
                       input logic [1:0] o2);
    logic [1:0] offs [3];
    offs[0] = o0; offs[1] = o1; offs[2] = o2;
    @(negedge clk);
    check("burst_idle", ifa.rsp_valid, 0);
    ifa.req_valid = 1'b1;
    ifa.req_addr  = {w, offs[0]};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("burst_rsp_valid", ifa.rsp_valid, 1);
      check("burst_rsp_data", ifa.rsp_data, pick(m_word, offs[i]));
      if (i < 2) ifa.req_addr = {w, offs[i+1]};
      else       ifa.req_valid = 1'b0;
      $display("txn burst addr=%03h data=%02h", {w, offs[i]}, ifa.rsp_data);
    end
    check("burst_miss_count", ifa.miss_count, 16'(m_miss));
    m_last = pick(m_word, offs[2]);
  endtask

  task automatic reset_mid_fetch(input logic [10:0] addr);
    int seen;
    @(negedge clk);
    ifa.req_valid = 1'b1;
    ifa.req_addr  = addr;
    @(negedge clk);
    ifa.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_csb", ifa.oram_csb, 1);
    check("rst_rsp_valid", ifa.rsp_valid, 0);
    check("rst_miss_count", ifa.miss_count, 0);
    check("rst_ready", ifa.req_ready, 1);
    check("rst_rsp_data", ifa.rsp_data, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ifa.rsp_valid) seen++;
    end
    check("rst_no_response", seen, 0);
    m_valid = 1'b0;
    m_miss  = 0;
    m_last  = '0;
    $display("txn reset during fetch addr=%03h", addr);
  endtask

  initial begin
    int         lat;
    logic [7:0] got;
    ifa.req_valid = 1'b0; ifa.req_addr = '0; ifa.flush = 1'b0;
    ifb.req_valid = 1'b0; ifb.req_addr = '0; ifb.flush = 1'b0;
    for (int i = 0; i < 512; i++) mem_a[i] = $urandom;
    for (int i = 0; i < 256; i++) mem_b[i] = {$urandom, $urandom};
    mem_a[2] = 32'h4433_2211;
    mem_b[0] = 64'h8877_6655_4433_2211;

    #1;
    check("reset_ready", ifa.req_ready, 1);
    check("reset_csb", ifa.oram_csb, 1);
    check("reset_rsp_valid", ifa.rsp_valid, 0);
    check("reset_rsp_data", ifa.rsp_data, 0);
    check("reset_oram_addr", ifa.oram_addr, 0);
    check("reset_miss_count", ifa.miss_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 8-byte words, latency 3.
    @(negedge clk);
    check("b_ready", ifb.req_ready, 1);
    ifb.req_valid = 1'b1;
    ifb.req_addr  = 11'h005;
    lat = 0;
    got = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) ifb.req_valid = 1'b0;
      if (ifb.rsp_valid) begin
        lat = k;
        got = ifb.rsp_data;
        break;
      end
    end
    check("b_latency", lat, 5);
    check("b_rsp_data", got, 8'h66);
    check("b_miss_count", ifb.miss_count, 1);
    check("b_oram_addr", ifb.oram_addr, 0);
    $display("txn wide addr=005 lat=%0d data=%02h", lat, got);

    issue(11'h009, 0, 1'b0);
    check("first_miss_byte", ifa.rsp_data, 8'h22);
    burst(9'd2, 2'd0, 2'd2, 2'd3);
    check("burst_keeps_misses", ifa.miss_count, 1);
    flush_pulse();
    issue(11'h008, 0, 1'b0);
    issue(11'h00C, 2, 1'b0);
    issue(11'h00C, 0, 1'b0);
    reset_mid_fetch(11'h010);
    issue(11'h009, 0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      int r;
      r = $urandom_range(0, 7);
      if (r == 0) flush_pulse();
      else if (r == 1 && m_valid)
        burst(m_tag, 2'($urandom), 2'($urandom), 2'($urandom));
      else
        issue(11'($urandom_range(0, 31)), $urandom_range(0, LAT + 1), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
